// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a time-multiplexed, active-low 7-segment bus.
// Each digit dwell must repeat STABLE_CYCLES identical samples before it is
// captured; a full set of captured digits is presented on a valid/ready port.
module seg7_scan_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:6]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned RUN_W  = 8;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  // Returns {invalid, code}; unknown patterns decode to an invalid 4'hF.
  function automatic logic [4:0] decode(input logic [0:6] s);
    case (s)
      7'b0000001: decode = 5'h00;
      7'b1001111: decode = 5'h01;
      7'b0010010: decode = 5'h02;
      7'b0000110: decode = 5'h03;
      7'b1001100: decode = 5'h04;
      7'b0100100: decode = 5'h05;
      7'b0100000: decode = 5'h06;
      7'b0001111: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0000100: decode = 5'h09;
      default:    decode = 5'h1F;
    endcase
  endfunction

  logic [DIGITS-1:0] prev_an;
  logic [0:6]        prev_seg;
  logic [RUN_W-1:0]  run;
  logic [DIGITS-1:0] seen;
  logic [DATA_W-1:0] shadow;
  logic [DIGITS-1:0] err_shadow;

  logic [CNT_W-1:0]  sel_cnt;
  logic              selected;
  logic              same;
  logic              capture;
  logic              complete;
  logic              xfer;
  logic [4:0]        dec;
  logic [RUN_W-1:0]  run_d;
  logic [DIGITS-1:0] seen_cap;
  logic [DIGITS-1:0] seen_d;
  logic [DATA_W-1:0] shadow_d;
  logic [DIGITS-1:0] err_shadow_d;
  logic [DATA_W-1:0] out_data_d;
  logic [DIGITS-1:0] out_err_d;
  logic              out_valid_d;
  logic              overrun_d;

  // Select qualification, dwell run length, capture and frame hand-off.
  always_comb begin
    sel_cnt      = '0;
    run_d        = '0;
    seen_cap     = seen;
    shadow_d     = shadow;
    err_shadow_d = err_shadow;
    out_data_d   = out_data;
    out_err_d    = out_err;
    out_valid_d  = out_valid;
    overrun_d    = overrun;
    dec          = decode(seg);

    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!an[i]) sel_cnt = sel_cnt + CNT_W'(1);
    end
    selected = (sel_cnt == CNT_W'(1));
    same     = (an == prev_an) && (seg == prev_seg);

    if (selected) begin
      if (same) run_d = (run == RUN_MAX) ? RUN_MAX : run + RUN_W'(1);
      else      run_d = RUN_W'(1);
    end

    // Saturated repeats of an already-captured dwell do not capture again.
    capture = selected && (run_d == RUN_MAX) && !(same && (run == RUN_MAX));

    if (capture) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (!an[i]) begin
          shadow_d[4*i +: 4] = dec[3:0];
          err_shadow_d[i]    = dec[4];
          seen_cap[i]        = 1'b1;
        end
      end
    end

    complete = capture && (&seen_cap);
    seen_d   = complete ? '0 : seen_cap;
    xfer     = out_valid && out_ready;

    if (xfer) begin
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (complete) begin
      if (!out_valid || out_ready) begin
        out_data_d  = shadow_d;
        out_err_d   = err_shadow_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_an    <= '1;
      prev_seg   <= 7'b1111111;
      run        <= '0;
      seen       <= '0;
      shadow     <= '0;
      err_shadow <= '0;
      out_data   <= '0;
      out_err    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      prev_an    <= an;
      prev_seg   <= seg;
      run        <= run_d;
      seen       <= seen_d;
      shadow     <= shadow_d;
      err_shadow <= err_shadow_d;
      out_data   <= out_data_d;
      out_err    <= out_err_d;
      out_valid  <= out_valid_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed vector table plus random scans,
// all checked every cycle against a sample-history reference model.
module tb_seg7_scan_reader;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic [15:0] out_data;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100};

  // Reference model state.
  logic [10:0] hq[$];
  logic [3:0]  m_sh   [4];
  logic        m_esh  [4];
  logic        m_seen [4];
  logic [15:0] m_data;
  logic [3:0]  m_err;
  logic        m_valid;
  logic        m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = 4'h0; m_esh[i] = 1'b0; m_seen[i] = 1'b0;
    end
    m_data = '0; m_err = '0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // Run length = number of trailing identical (an,seg) samples incl. this one.
  task automatic model_step();
    logic [10:0] cur;
    int run, zeros, slot, code;
    logic inv, all_seen;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cur = {an, 7'(seg)};
    run = 1;
    for (int k = hq.size() - 1; k >= 0; k--) begin
      if (hq[k] == cur) run++;
      else break;
    end
    hq.push_back(cur);
    if (hq.size() > 300) void'(hq.pop_front());
    zeros = 0; slot = 0;
    for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin zeros++; slot = i; end
    if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
    if (zeros == 1 && run == int'(STABLE)) begin
      code = 15; inv = 1'b1;
      for (int p = 0; p < 10; p++) if (pat[p] == 7'(seg)) begin code = p; inv = 1'b0; end
      m_sh[slot] = 4'(code); m_esh[slot] = inv; m_seen[slot] = 1'b1;
      all_seen = 1'b1;
      for (int i = 0; i < 4; i++) all_seen &= m_seen[i];
      if (all_seen) begin
        if (!m_valid || out_ready) begin
          for (int i = 0; i < 4; i++) begin
            m_data[4*i +: 4] = m_sh[i];
            m_err[i]         = m_esh[i];
          end
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
      end
    end
  endtask

  // One clock: model follows the sampled inputs, outputs compared after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("valid",   32'(out_valid), 32'(m_valid));
    check("data",    32'(out_data),  32'(m_data));
    check("err",     32'(out_err),   32'(m_err));
    check("overrun", 32'(overrun),   32'(m_ovr));
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        rdy;
    int          n;
    logic        chk;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  ee;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] a, logic [6:0] s, logic rdy, int n,
                              logic chk, logic ev, logic [15:0] ed, logic [3:0] ee, logic eo);
    vec_t v;
    v.rst = rst; v.an = a; v.seg = s; v.rdy = rdy; v.n = n;
    v.chk = chk; v.ev = ev; v.ed = ed; v.ee = ee; v.eo = eo;
    return v;
  endfunction

  initial begin
    int r, len;
    logic [6:0] P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, PX;
    P0 = pat[0]; P1 = pat[1]; P2 = pat[2]; P3 = pat[3]; P4 = pat[4];
    P5 = pat[5]; P6 = pat[6]; P7 = pat[7]; P8 = pat[8]; P9 = pat[9];
    PX = 7'b1111111;
    model_reset();

    // Nominal scan: valid exactly on the 16th edge.
    tbl.push_back(mk(1, 4'b1110, P1, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P2, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1011, P3, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, P4, 0, 3, 1, 0, 16'h0000, 4'h0, 0));
    tbl.push_back(mk(1, 4'b0111, P4, 0, 1, 1, 1, 16'h4321, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1111, PX, 1, 1, 1, 0, 16'h4321, 4'h0, 0));
    // Glitch rejection: short dwell, double select ignored.
    tbl.push_back(mk(1, 4'b1110, P5, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1110, P6, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1100, PX, 0, 8, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P7, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1011, P8, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, P9, 0, 4, 1, 0, 16'h4321, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1110, P0, 0, 3, 1, 0, 16'h4321, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1110, P0, 0, 1, 1, 1, 16'h9870, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1111, PX, 1, 1, 1, 0, 16'h9870, 4'h0, 0));
    // Invalid pattern on digit 2.
    tbl.push_back(mk(1, 4'b1110, P0, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P0, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1011, PX, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, P0, 0, 4, 1, 1, 16'h0F00, 4'b0100, 0));
    tbl.push_back(mk(1, 4'b1111, PX, 1, 1, 1, 0, 16'h0F00, 4'b0100, 0));
    // Backpressure: frame B dropped, overrun set then cleared on transfer.
    tbl.push_back(mk(1, 4'b1110, P4, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P3, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1011, P2, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, P1, 0, 4, 1, 1, 16'h1234, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1110, P8, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P7, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1011, P6, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, P5, 0, 4, 1, 1, 16'h1234, 4'h0, 1));
    tbl.push_back(mk(1, 4'b1111, PX, 1, 1, 1, 0, 16'h1234, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1110, P9, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P9, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1011, P9, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, P9, 0, 4, 1, 1, 16'h9999, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1111, PX, 1, 1, 1, 0, 16'h9999, 4'h0, 0));
    // Reset mid-frame discards digits 0 and 1.
    tbl.push_back(mk(1, 4'b1110, P1, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P2, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b1111, PX, 0, 1, 1, 0, 16'h0000, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1011, P3, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, P4, 0, 4, 1, 0, 16'h0000, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1110, P1, 0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1101, P2, 0, 4, 1, 1, 16'h4321, 4'h0, 0));
    tbl.push_back(mk(1, 4'b1111, PX, 1, 1, 0, 0, 0, 0, 0));

    // Reset with random bus activity.
    rst_n = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      an = 4'($urandom); seg = 7'($urandom);
      cycle();
    end
    check("rst_valid",   32'(out_valid), 32'h0);
    check("rst_data",    32'(out_data),  32'h0);
    check("rst_err",     32'(out_err),   32'h0);
    check("rst_overrun", 32'(overrun),   32'h0);
    rst_n = 1'b1; an = 4'b1111; seg = PX;
    for (int k = 0; k < 10; k++) cycle();
    check("idle_valid", 32'(out_valid), 32'h0);
    check("idle_data",  32'(out_data),  32'h0);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst; an = tbl[i].an; seg = tbl[i].seg; out_ready = tbl[i].rdy;
      for (int k = 0; k < tbl[i].n; k++) cycle();
      if (tbl[i].chk) begin
        check($sformatf("row%0d_valid", i),   32'(out_valid), 32'(tbl[i].ev));
        check($sformatf("row%0d_data", i),    32'(out_data),  32'(tbl[i].ed));
        check($sformatf("row%0d_err", i),     32'(out_err),   32'(tbl[i].ee));
        check($sformatf("row%0d_overrun", i), 32'(overrun),   32'(tbl[i].eo));
      end
    end
    rst_n = 1'b1;

    // Random dwells, occasional multi-select, bad patterns, resets, backpressure.
    for (int d = 0; d < 400; d++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0; an = 4'b1111;
        cycle();
        rst_n = 1'b1;
      end
      r = int'($urandom_range(0, 19));
      if (r < 17) an = ~(4'(4'b0001 << $urandom_range(0, 3)));
      else        an = 4'($urandom);
      if ($urandom_range(0, 4) != 0) seg = pat[$urandom_range(0, 9)];
      else                           seg = 7'($urandom);
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        out_ready = ($urandom_range(0, 3) == 0);
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
